// File: rtl/pci_bus_arbiter.sv
// Central round-robin arbiter for a shared PCI bus. It parks the bus on a default master,
// arbitrates hidden behind the current transaction, and only observes FRAME/IRDY.
module pci_bus_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int PARK_MASTER   = 0,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                   CLK,
    input  logic                   REST,
    input  logic [NUM_MASTERS-1:0] REQ,
    input  logic                   FRAME,
    input  logic                   IRDY,
    output logic [NUM_MASTERS-1:0] GNT,
    output logic [2:0]             OWNER,
    output logic                   BUS_IDLE
);

    typedef enum logic [1:0] {
        ST_PARK,
        ST_GRANT,
        ST_BUSY,
        ST_SWITCH
    } state_t;

    localparam logic [2:0]             PARK_IDX = 3'(PARK_MASTER);
    localparam logic [2:0]             LAST_IDX = 3'(NUM_MASTERS - 1);
    localparam logic [7:0]             TMAX     = 8'(GRANT_TIMEOUT - 1);
    localparam logic [3:0]             NM4      = 4'(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] ALL_OFF  = '1;

    state_t                   state_q, state_d;
    logic [2:0]               owner_q, owner_d;
    logic [2:0]               rrPtr_q, rrPtr_d;
    logic [7:0]               timer_q, timer_d;
    logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
    logic                     busIdle_q;
    logic                     armed_q;

    logic [7:0]               reqAct;
    logic                     winValid;
    logic [2:0]               winIdx;
    logic                     otherReq;
    logic                     onlyOwner;
    logic                     ownerGranted;
    logic                     busStart;
    logic                     busEnd;

    function automatic logic [NUM_MASTERS-1:0] gntFor(input logic [2:0] who);
        gntFor = ~(ONE_HOT0 << who);
    endfunction

    function automatic logic [2:0] nextIdx(input logic [2:0] who);
        nextIdx = (who == LAST_IDX) ? 3'd0 : who + 3'd1;
    endfunction

    // Request decode and round-robin winner search starting at the priority pointer.
    always_comb begin
        logic [3:0] sum;
        reqAct                   = '0;
        reqAct[NUM_MASTERS-1:0]  = ~REQ;
        winValid                 = 1'b0;
        winIdx                   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            sum = {1'b0, rrPtr_q} + 4'(k);
            if (sum >= NM4) begin
                sum = sum - NM4;
            end
            if (!winValid && reqAct[sum[2:0]]) begin
                winValid = 1'b1;
                winIdx   = sum[2:0];
            end
        end
        otherReq     = |(reqAct & ~(8'b1 << owner_q));
        onlyOwner    = reqAct[owner_q] && !otherReq;
        ownerGranted = (gnt_q == gntFor(owner_q));
        busStart     = !FRAME && busIdle_q && armed_q;
        busEnd       = FRAME && IRDY;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        timer_d = timer_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_PARK: begin
                owner_d = PARK_IDX;
                gnt_d   = gntFor(PARK_IDX);
                if (busStart) begin
                    state_d = ST_BUSY;
                end else if (winValid && winIdx == PARK_IDX) begin
                    state_d = ST_GRANT;
                    timer_d = '0;
                end else if (winValid) begin
                    state_d = ST_SWITCH;
                    gnt_d   = ALL_OFF;
                end
            end
            ST_GRANT: begin
                if (busStart) begin
                    state_d = ST_BUSY;
                    timer_d = '0;
                    rrPtr_d = nextIdx(owner_q);
                end else if (!reqAct[owner_q]) begin
                    state_d = ST_SWITCH;
                    gnt_d   = ALL_OFF;
                    timer_d = '0;
                end else if (timer_q == TMAX) begin
                    state_d = ST_SWITCH;
                    gnt_d   = ALL_OFF;
                    timer_d = '0;
                    rrPtr_d = nextIdx(owner_q);
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            // A removed grant stays removed until the transaction ends.
            ST_BUSY: begin
                if (busEnd) begin
                    if (ownerGranted && onlyOwner) begin
                        state_d = ST_GRANT;
                        timer_d = '0;
                    end else begin
                        state_d = ST_SWITCH;
                        gnt_d   = ALL_OFF;
                    end
                end else if (otherReq) begin
                    gnt_d = ALL_OFF;
                end
            end
            ST_SWITCH: begin
                timer_d = '0;
                if (winValid) begin
                    state_d = ST_GRANT;
                    owner_d = winIdx;
                    gnt_d   = gntFor(winIdx);
                end else begin
                    state_d = ST_PARK;
                    owner_d = PARK_IDX;
                    gnt_d   = gntFor(PARK_IDX);
                end
            end
            default: begin
                state_d = ST_PARK;
                gnt_d   = ALL_OFF;
            end
        endcase
    end

    // Start detection needs a fresh idle sample after reset, hence the armed flag.
    always_ff @(posedge CLK or posedge REST) begin
        if (REST) begin
            state_q   <= ST_PARK;
            owner_q   <= PARK_IDX;
            rrPtr_q   <= '0;
            timer_q   <= '0;
            gnt_q     <= ALL_OFF;
            busIdle_q <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rrPtr_q   <= rrPtr_d;
            timer_q   <= timer_d;
            gnt_q     <= gnt_d;
            busIdle_q <= FRAME & IRDY;
            armed_q   <= armed_q | (FRAME & IRDY);
        end
    end

    assign GNT      = gnt_q;
    assign OWNER    = owner_q;
    assign BUS_IDLE = busIdle_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter: parking, round-robin, timeout, hidden arbitration
// and asynchronous reset mid-transaction, with hand-derived expected grants.
module tb_pci_bus_arbiter;

    logic       CLK = 1'b0;
    logic       REST = 1'b0;
    logic [3:0] REQ = 4'hF;
    logic       FRAME = 1'b1;
    logic       IRDY = 1'b1;
    logic [3:0] GNT;
    logic [2:0] OWNER;
    logic       BUS_IDLE;

    int checks = 0;
    int errors = 0;

    pci_bus_arbiter #(
        .NUM_MASTERS  (4),
        .PARK_MASTER  (0),
        .GRANT_TIMEOUT(16)
    ) dut (
        .CLK     (CLK),
        .REST    (REST),
        .REQ     (REQ),
        .FRAME   (FRAME),
        .IRDY    (IRDY),
        .GNT     (GNT),
        .OWNER   (OWNER),
        .BUS_IDLE(BUS_IDLE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] gntOf(input logic [2:0] who);
        logic [3:0] one;
        one   = 4'b0001;
        gntOf = ~(one << who);
    endfunction

    task automatic applyStimulus(input logic [3:0] req, input logic frame, input logic irdy);
        REQ   = req;
        FRAME = frame;
        IRDY  = irdy;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkGnt(input string tag, input logic [3:0] expGnt);
        checks++;
        assert (GNT === expGnt)
        else begin
            errors++;
            $error("[TB] FAIL %s GNT observed=%b expected=%b", tag, GNT, expGnt);
        end
        checks++;
        assert ($countones(~GNT) <= 1)
        else begin
            errors++;
            $error("[TB] FAIL %s onehot GNT observed=%b expected at most one low bit", tag, GNT);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expGnt,
                               input logic [2:0] expOwner, input logic expIdle);
        checkGnt(tag, expGnt);
        checks++;
        assert (OWNER === expOwner)
        else begin
            errors++;
            $error("[TB] FAIL %s OWNER observed=%0d expected=%0d", tag, OWNER, expOwner);
        end
        checks++;
        assert (BUS_IDLE === expIdle)
        else begin
            errors++;
            $error("[TB] FAIL %s BUS_IDLE observed=%b expected=%b", tag, BUS_IDLE, expIdle);
        end
    endtask

    initial begin
        logic [2:0] own;
        logic [2:0] nxt;

        #2 REST = 1'b1;
        @(posedge CLK); #1;
        checkOutput("reset_a", 4'b1111, 3'd0, 1'b1);
        @(posedge CLK); #1;
        checkOutput("reset_b", 4'b1111, 3'd0, 1'b1);
        REST = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 1'b1, 1'b1);
            checkOutput("park_idle", 4'b1110, 3'd0, 1'b1);
        end

        // Master 1 requests while parked on 0, then starts a transaction.
        applyStimulus(4'b1101, 1'b1, 1'b1);
        checkGnt("park_switch", 4'b1111);
        applyStimulus(4'b1101, 1'b1, 1'b1);
        checkOutput("grant_m1", 4'b1101, 3'd1, 1'b1);
        applyStimulus(4'b1101, 1'b0, 1'b1);
        checkOutput("busy_m1", 4'b1101, 3'd1, 1'b0);

        // Master 3 requests mid-transaction: grant removed, handed over after end + switch.
        applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("hidden_remove", 4'b1111, 3'd1, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("hidden_stay", 4'b1111, 3'd1, 1'b0);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkGnt("hidden_last", 4'b1111);
        applyStimulus(4'b0101, 1'b1, 1'b1);
        checkOutput("hidden_end", 4'b1111, 3'd1, 1'b1);
        applyStimulus(4'b0101, 1'b1, 1'b1);
        checkOutput("grant_m3", 4'b0111, 3'd3, 1'b1);

        // Masters 1 and 3 alternate, each running a three-data-phase transaction.
        own = 3'd3;
        for (int t = 0; t < 3; t++) begin
            nxt = (own == 3'd3) ? 3'd1 : 3'd3;
            applyStimulus(4'b0101, 1'b0, 1'b0);
            checkOutput("rr_start", gntOf(own), own, 1'b0);
            applyStimulus(4'b0101, 1'b0, 1'b0);
            checkOutput("rr_hidden", 4'b1111, own, 1'b0);
            applyStimulus(4'b0101, 1'b1, 1'b0);
            checkGnt("rr_data", 4'b1111);
            applyStimulus(4'b0101, 1'b1, 1'b1);
            checkGnt("rr_end", 4'b1111);
            applyStimulus(4'b0101, 1'b1, 1'b1);
            checkOutput("rr_next", gntOf(nxt), nxt, 1'b1);
            own = nxt;
        end

        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkGnt("withdraw", 4'b1111);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkOutput("repark", 4'b1110, 3'd0, 1'b1);

        // Master 2 granted but never starts; master 0 joins and wins after the timeout.
        applyStimulus(4'b1011, 1'b1, 1'b1);
        checkGnt("to_switch", 4'b1111);
        applyStimulus(4'b1011, 1'b1, 1'b1);
        checkOutput("to_grant_m2", 4'b1011, 3'd2, 1'b1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(4'b1010, 1'b1, 1'b1);
            checkOutput("to_hold", 4'b1011, 3'd2, 1'b1);
        end
        applyStimulus(4'b1010, 1'b1, 1'b1);
        checkGnt("to_revoke", 4'b1111);
        applyStimulus(4'b1010, 1'b1, 1'b1);
        checkOutput("to_m0_first", 4'b1110, 3'd0, 1'b1);

        // Asynchronous reset while master 0 owns a transaction.
        applyStimulus(4'b1010, 1'b0, 1'b0);
        checkOutput("rst_busy", 4'b1110, 3'd0, 1'b0);
        applyStimulus(4'b1110, 1'b0, 1'b0);
        checkOutput("rst_busy_hold", 4'b1110, 3'd0, 1'b0);
        REQ  = 4'b1111;
        REST = 1'b1;
        #1;
        checkOutput("rst_async", 4'b1111, 3'd0, 1'b1);
        @(posedge CLK); #1;
        REST = 1'b0;
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("rst_park", 4'b1110, 3'd0, 1'b0);
        applyStimulus(4'b1101, 1'b0, 1'b0);
        checkGnt("rst_no_busy_sw", 4'b1111);
        applyStimulus(4'b1101, 1'b0, 1'b0);
        checkOutput("rst_no_busy_gnt", 4'b1101, 3'd1, 1'b0);
        applyStimulus(4'b1101, 1'b1, 1'b1);
        checkOutput("rst_idle", 4'b1101, 3'd1, 1'b1);
        applyStimulus(4'b1101, 1'b0, 1'b1);
        checkOutput("rst_fresh_start", 4'b1101, 3'd1, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b1);
        checkOutput("rst_busy_hidden", 4'b1111, 3'd1, 1'b0);
        applyStimulus(4'b0101, 1'b1, 1'b1);
        checkGnt("rst_end", 4'b1111);
        applyStimulus(4'b0101, 1'b1, 1'b1);
        checkOutput("rst_grant_m3", 4'b0111, 3'd3, 1'b1);

        // Sole requester keeps its grant across the end of its own transaction.
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("solo_busy", 4'b0111, 3'd3, 1'b0);
        applyStimulus(4'b0111, 1'b1, 1'b1);
        checkOutput("solo_regrant", 4'b0111, 3'd3, 1'b1);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkGnt("solo_withdraw", 4'b1111);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkOutput("solo_park", 4'b1110, 3'd0, 1'b1);

        // Parked master starts without requesting; master 2 waits for the end.
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("park_start", 4'b1110, 3'd0, 1'b0);
        applyStimulus(4'b1011, 1'b0, 1'b0);
        checkGnt("park_hidden", 4'b1111);
        applyStimulus(4'b1011, 1'b1, 1'b1);
        checkGnt("park_end", 4'b1111);
        applyStimulus(4'b1011, 1'b1, 1'b1);
        checkOutput("park_to_m2", 4'b1011, 3'd2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central arbiter for the shared PCI bus: AD, CBE, FRAME, IRDY, TRDY and DEVSEL.
- Receives active-low REQ from up to NUM_MASTERS initiators and drives one active-low GNT per initiator.
- Arbitration is round-robin. The bus is parked on a default master when nobody requests. Hidden arbitration runs during a transaction.
- Monitors FRAME/IRDY to detect transaction start and end; it never drives the bus itself.

Parameters:
- NUM_MASTERS, 4, number of REQ/GNT pairs; legal range 2..8.
- PARK_MASTER, 0, index of the master granted when no request is pending.
- GRANT_TIMEOUT, 16, cycles a granted master has to start FRAME before its grant is revoked; legal range 2..255.

Ports:
- CLK  input  1  bus clock; all state is updated on the rising edge.
- REST  input  1  reset; asynchronous, active-high.
- REQ  input  NUM_MASTERS  per-master request, active-low.
- FRAME  input  1  bus FRAME, active-low.
- IRDY  input  1  bus IRDY, active-low.
- GNT  output  NUM_MASTERS  per-master grant, active-low, registered.
- OWNER  output  3  index of the current grantee or bus owner, registered.
- BUS_IDLE  output  1  registered (FRAME & IRDY); 1 means the bus is idle.

Behaviour:
- Reset: while REST=1, GNT is all ones, OWNER=PARK_MASTER, BUS_IDLE=1, state=PARK, rr_ptr=0, timer=0. GNT[PARK_MASTER] goes low at the first CLK edge after REST falls.
- Start of transaction (start): FRAME=0 sampled while BUS_IDLE=1 (the bus was idle on the previous edge).
- End of transaction (end): FRAME=1 and IRDY=1 sampled while in BUSY.
- Winner: the first index with REQ=0, searched from rr_ptr upward and wrapping modulo NUM_MASTERS. "No winner" means REQ is all ones.
- Grant-change rule: GNT never moves directly from one master to another. Every change of grantee passes through at least one cycle with GNT all ones.
- At most one GNT bit is low at any time.
- State PARK:
  - GNT[PARK_MASTER]=0, OWNER=PARK_MASTER.
  - start → BUSY, owner=PARK_MASTER, even if it did not request.
  - Otherwise, if winner==PARK_MASTER → GRANT.
  - Otherwise, if a winner exists → SWITCH.
  - start has priority over a pending request in the same cycle.
- State GRANT:
  - GNT[OWNER]=0 and the timer increments each cycle.
  - start → BUSY; timer cleared; rr_ptr=(OWNER+1) mod NUM_MASTERS.
  - REQ[OWNER]=1 before start (request withdrawn) → SWITCH.
  - timer reaches GRANT_TIMEOUT-1 with no start → SWITCH; rr_ptr=(OWNER+1) mod NUM_MASTERS.
  - start wins over timeout in the same cycle.
- State BUSY (hidden arbitration):
  - If any master other than OWNER has REQ=0, GNT goes to all ones on the next edge so the owner releases the bus. Otherwise GNT[OWNER] stays 0.
  - Once removed, GNT is not re-given to the owner during this transaction.
  - end with GNT[OWNER] still 0, and the owner the only requester → GRANT with the same OWNER (no dead cycle needed).
  - Any other end → SWITCH.
  - FRAME held low indefinitely keeps the arbiter in BUSY; there is no timeout in BUSY.
- State SWITCH:
  - Exactly one cycle; GNT all ones.
  - Winner computed from the REQ sampled in this cycle.
  - Winner exists → GRANT, OWNER=winner, timer=0.
  - Otherwise → PARK.
- rr_ptr changes only on GRANT→BUSY, on timeout revocation, or on reset. A master that won stays lowest priority until every other requester has been served.
- Reset asserted mid-transaction: GNT goes to all ones immediately (asynchronously) regardless of FRAME. After release, the arbiter parks even if FRAME is still low. It does not enter BUSY until a fresh idle→FRAME=0 start is seen.
- OWNER upper bits beyond clog2(NUM_MASTERS) are 0.

Test Plan:
- Reset, all REQ=1, no traffic for 5 cycles → GNT=4'b1110, OWNER=0, BUS_IDLE=1 every cycle.
- REQ=4'b1101 while parked on master 0 → one cycle GNT=4'b1111, then GNT=4'b1101, OWNER=1. FRAME low next cycle → BUSY; rr_ptr=2.
- REQ=4'b0101 (masters 1 and 3) together, each granted master running a 3-data-phase transaction → grant order 1, 3, 1, 3. Every handover shows a GNT=4'b1111 cycle. GNT is never low on two bits.
- Master 2 granted, never drives FRAME, REQ held low → GNT[2]=0 for exactly 16 cycles, then SWITCH. With master 0 also requesting, master 0 is granted before master 2 again.
- Master 1 in BUSY, master 3 asserts REQ mid-transaction → GNT=4'b1111 on the next edge. Master 3 gets GNT[3]=0 only after FRAME=1 and IRDY=1 are sampled and one SWITCH cycle has passed.
- REST=1 raised while FRAME=0 in BUSY → GNT=4'b1111 in the same cycle. After release with FRAME still 0 → GNT=4'b1110 and no BUSY entry until the bus goes idle and FRAME falls again.
